fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned BYTE_AW       = 16;
    localparam int unsigned WORD_AW       = 15;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: registered storage and pointers; flush wins over push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // Head is forced to zero when empty so stale words never leak out.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetch unit: single-outstanding memory fetcher feeding a FIFO,
// with redirect flush and odd-byte entry tagging.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [WORD_AW-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [15:0]        mem_data,
    input  logic               redirect,
    input  logic [BYTE_AW-1:0] redirect_ip,
    output logic               instr_valid,
    output logic [15:0]        instr_word,
    output logic               instr_odd,
    input  logic               instr_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t             state_q, state_d;
    logic [WORD_AW-1:0] fp_q, fp_d;
    logic               odd_pend_q, odd_pend_d;

    logic               push, pop;
    logic [CW-1:0]      count, occ_after;
    logic               full, empty;
    logic [16:0]        head;

    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;
    assign push        = (state_q == REQ) && mem_ack && !redirect;
    assign occ_after   = count + CW'(push) - CW'(pop);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (17)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({odd_pend_q, mem_data}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fp_q       <= '0;
            odd_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fp_q       <= fp_d;
            odd_pend_q <= odd_pend_d;
        end
    end

    // DROP keeps mem_req high until the stale ack arrives, then restarts at fp.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!redirect && !full) state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    state_d = mem_ack ? REQ : DROP;
                end else if (mem_ack) begin
                    state_d = (occ_after < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (mem_ack) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fp_d       = fp_q;
        odd_pend_d = odd_pend_q;
        if (redirect) begin
            fp_d       = redirect_ip[BYTE_AW-1:1];
            odd_pend_d = redirect_ip[0];
        end else if (push) begin
            fp_d       = fp_q + WORD_AW'(1);
            odd_pend_d = 1'b0;
        end
    end

    always_comb begin
        mem_req    = (state_q != IDLE);
        mem_addr   = mem_req ? fp_q : '0;
        instr_word = head[15:0];
        instr_odd  = head[16];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        redirect;
    logic [15:0] redirect_ip;
    logic        instr_valid;
    logic [15:0] instr_word;
    logic        instr_odd;
    logic        instr_ready;

    fetch_unit #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_ip (redirect_ip),
        .instr_valid (instr_valid),
        .instr_word  (instr_word),
        .instr_odd   (instr_odd),
        .instr_ready (instr_ready)
    );

    typedef struct {
        logic [14:0] addr;
        logic [15:0] exp_word;
        logic        exp_odd;
    } vec_t;

    int          passed = 0;
    int          total  = 0;
    int          lat    = 0;
    logic        stray_ack = 0;
    logic [16:0] got [$];
    logic [14:0] req_log [$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_rd(input logic [14:0] a);
        case (a)
            15'd0:   return 16'h8001;
            15'd1:   return 16'h8002;
            15'd2:   return 16'h0300;
            15'd3:   return 16'h0C00;
            default: return {1'b0, a} ^ 16'hC3C3;
        endcase
    endfunction

    // Memory: latches the address when a request starts, acks after lat wait cycles.
    initial begin
        logic        busy;
        logic [14:0] cur_addr;
        int          wait_n;
        busy     = 0;
        cur_addr = '0;
        wait_n   = 0;
        mem_ack  = 0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack  = 0;
            mem_data = '0;
            if (stray_ack) begin
                mem_ack   = 1;
                mem_data  = 16'hDEAD;
                stray_ack = 0;
                busy      = 0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy     = 1;
                    cur_addr = mem_addr;
                    wait_n   = lat;
                    req_log.push_back(mem_addr);
                end
                if (wait_n == 0) begin
                    mem_ack  = 1;
                    mem_data = mem_rd(cur_addr);
                    busy     = 0;
                end else begin
                    wait_n--;
                end
            end else begin
                busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) got.push_back({instr_odd, instr_word});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_words(input int n, input string name);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (got.size() < n) begin
            total++;
            $display("FAIL %s: got %0d words, expected %0d", name, got.size(), n);
        end
    endtask

    task automatic do_reset();
        rst         = 1;
        redirect    = 0;
        redirect_ip = '0;
        instr_ready = 0;
        repeat (3) @(negedge clk);
        got.delete();
        req_log.delete();
        rst = 0;
    endtask

    initial begin
        vec_t        tv [4];
        logic [14:0] dropped;
        int          cyc;

        tv[0] = '{addr: 15'd0, exp_word: 16'h8001, exp_odd: 1'b0};
        tv[1] = '{addr: 15'd1, exp_word: 16'h8002, exp_odd: 1'b0};
        tv[2] = '{addr: 15'd2, exp_word: 16'h0300, exp_odd: 1'b0};
        tv[3] = '{addr: 15'd3, exp_word: 16'h0C00, exp_odd: 1'b0};

        rst         = 1;
        redirect    = 0;
        redirect_ip = '0;
        instr_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_word", 32'(instr_word), 32'd0);
        chk("rst_odd", 32'(instr_odd), 32'd0);

        // Streaming with ack every cycle and CPU always ready.
        lat = 0;
        do_reset();
        instr_ready = 1;
        @(posedge clk); #1;
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", 32'(mem_addr), 32'd0);
        wait_words(4, "stream_words");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stream_addr%0d", i), 32'(req_log[i]), 32'(tv[i].addr));
            chk($sformatf("stream_word%0d", i), 32'(got[i][15:0]), 32'(tv[i].exp_word));
            chk($sformatf("stream_odd%0d", i), 32'(got[i][16]), 32'(tv[i].exp_odd));
        end

        // Stalled CPU fills the FIFO; one pop lets exactly one more request out.
        lat = 1;
        do_reset();
        repeat (30) @(posedge clk);
        #1;
        chk("fill_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_addr%0d", i), 32'(req_log[i]), 32'(i));
        end
        chk("fill_mem_req", 32'(mem_req), 32'd0);
        chk("fill_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1;
        @(posedge clk); #1;
        instr_ready = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("pop_word", 32'(got[0]), 32'h08001);
        chk("refill_req_count", 32'(req_log.size()), 32'd5);
        chk("refill_addr", 32'(req_log[4]), 32'd4);
        chk("refill_mem_req", 32'(mem_req), 32'd0);

        // Redirect to an odd byte address while a slow request is pending.
        lat = 3;
        do_reset();
        instr_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        redirect    = 1;
        redirect_ip = 16'h0101;
        @(posedge clk); #1;
        redirect = 0;
        chk("drop_mem_addr", 32'(mem_addr), 32'h0080);
        chk("drop_mem_req", 32'(mem_req), 32'd1);
        chk("drop_valid", 32'(instr_valid), 32'd0);
        wait_words(2, "drop_words");
        chk("drop_first", 32'(got[0]), {15'd0, 1'b1, mem_rd(15'h0080)});
        chk("drop_second", 32'(got[1]), {15'd0, 1'b0, mem_rd(15'h0081)});
        chk("drop_new_req", 32'(req_log[1]), 32'h0080);

        // Redirect in the same cycle as an ack and a pop.
        lat = 0;
        do_reset();
        instr_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("coinc_pre_valid", 32'(instr_valid), 32'd1);
        dropped     = mem_addr;
        redirect    = 1;
        redirect_ip = 16'h0200;
        @(posedge clk); #1;
        redirect = 0;
        got.delete();
        chk("coinc_valid", 32'(instr_valid), 32'd0);
        chk("coinc_mem_req", 32'(mem_req), 32'd1);
        chk("coinc_mem_addr", 32'(mem_addr), 32'h0100);
        wait_words(2, "coinc_words");
        chk("coinc_first", 32'(got[0]), {15'd0, 1'b0, mem_rd(15'h0100)});
        chk("coinc_second", 32'(got[1]), {15'd0, 1'b0, mem_rd(15'h0101)});
        chk("coinc_not_stale", 32'(got[0][15:0] == mem_rd(dropped)), 32'd0);

        // Fetch pointer wrap at the top of the word address space.
        lat = 0;
        do_reset();
        instr_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        redirect    = 1;
        redirect_ip = 16'hFFFE;
        @(posedge clk); #1;
        redirect = 0;
        got.delete();
        chk("wrap_addr_top", 32'(mem_addr), 32'h7FFF);
        @(posedge clk); #1;
        chk("wrap_addr_zero", 32'(mem_addr), 32'h0000);
        wait_words(2, "wrap_words");
        chk("wrap_first", 32'(got[0]), {15'd0, 1'b0, mem_rd(15'h7FFF)});
        chk("wrap_second", 32'(got[1]), {15'd0, 1'b0, mem_rd(15'h0000)});

        // Reset asserted mid-request with a nearly full FIFO, then a stray ack.
        lat = 4;
        do_reset();
        cyc = 0;
        while (req_log.size() < 4 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("mid_pre_valid", 32'(instr_valid), 32'd1);
        chk("mid_pre_req", 32'(mem_req), 32'd1);
        rst = 1;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_word", 32'(instr_word), 32'd0);
        chk("mid_rst_odd", 32'(instr_odd), 32'd0);
        lat         = 0;
        instr_ready = 1;
        stray_ack   = 1;
        got.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        chk("stray_mem_req", 32'(mem_req), 32'd1);
        chk("stray_mem_addr", 32'(mem_addr), 32'd0);
        chk("stray_valid", 32'(instr_valid), 32'd0);
        wait_words(1, "stray_words");
        chk("stray_first", 32'(got[0]), 32'h08001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
